four_input_and_reg: RTL and testbench

//   Registered four-input AND stage: bitwise AND of inputs a,b (-> e) and c,d (-> f),

---
 rtl/four_input_and_reg.sv | 47 ++++
 tb/tb_four_input_and_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/four_input_and_reg.sv
// four_input_and_reg: registered 2x2-input AND pairs plus the 4-way AND.
// One-cycle latency, sample enable, valid flag, async active-low reset.
module four_input_and_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic             valid_out
);

    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] cd;
    logic [WIDTH-1:0] abcd;

    // Partial products; g comes from the same sample, not the stale e/f.
    always_comb begin
        ab   = a & b;
        cd   = c & d;
        abcd = ab & cd;
    end

    // Capture on en, hold otherwise; valid marks a fresh capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e         <= '0;
            f         <= '0;
            g         <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= en;
            if (en) begin
                e <= ab;
                f <= cd;
                g <= abcd;
            end
        end
    end

endmodule

// File: tb/tb_four_input_and_reg.sv
// tb_four_input_and_reg: directed checks of four_input_and_reg.
// Covers WIDTH=1 exhaustively and WIDTH=4 lane independence.
module tb_four_input_and_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       a1, b1, c1, d1;
    logic       e1, f1, g1, v1;
    logic [3:0] a4, b4, c4, d4;
    logic [3:0] e4, f4, g4;
    logic       v4;

    int vec  = 0;
    int errs = 0;

    four_input_and_reg #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .e(e1), .f(f1), .g(g1), .valid_out(v1)
    );

    four_input_and_reg #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a(a4), .b(b4), .c(c4), .d(d4),
        .e(e4), .f(f4), .g(g4), .valid_out(v4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] e_x,
                        input logic [3:0] f_x, input logic [3:0] g_x,
                        input logic v_x);
        chk({tag, ".e"}, {3'b0, e1}, e_x);
        chk({tag, ".f"}, {3'b0, f1}, f_x);
        chk({tag, ".g"}, {3'b0, g1}, g_x);
        chk({tag, ".v"}, {3'b0, v1}, {3'b0, v_x});
    endtask

    task automatic set1(input logic [3:0] v);
        a1 = v[3]; b1 = v[2]; c1 = v[1]; d1 = v[0];
    endtask

    initial begin
        // Reset with all inputs high and en asserted
        rst_n = 1'b0;
        en    = 1'b1;
        set1(4'b1111);
        a4 = 4'hf; b4 = 4'hf; c4 = 4'hf; d4 = 4'hf;
        #2;
        chk1("rst_pre", 0, 0, 0, 0);
        chk("rst_pre.g4", g4, 4'h0);
        chk("rst_pre.v4", {3'b0, v4}, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_post", 0, 0, 0, 0);
        chk("rst_post.e4", e4, 4'h0);
        chk("rst_post.g4", g4, 4'h0);

        // Exhaustive walk, one value per cycle, d fastest
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'h0; b4 = 4'h0; c4 = 4'h0; d4 = 4'h0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            set1(v);
            @(posedge clk);
            #1;
            chk1($sformatf("walk%0d", i),
                 {3'b0, v[3] & v[2]},
                 {3'b0, v[1] & v[0]},
                 {3'b0, &v}, 1'b1);
            @(negedge clk);
        end

        // Hold: capture 1111 then en=0 with inputs 0
        set1(4'b1111);
        @(posedge clk);
        #1;
        chk1("hold_cap", 1, 1, 1, 1);
        @(negedge clk);
        en = 1'b0;
        set1(4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("hold%0d", k), 1, 1, 1, 0);
        end

        // Async reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        set1(4'b1111);
        @(posedge clk);
        #1;
        chk1("post_rel", 1, 1, 1, 1);

        // Lane independence on the 4-bit instance
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b1010; c4 = 4'b0110; d4 = 4'b1111;
        @(posedge clk);
        #1;
        chk("lane.e", e4, 4'b1010);
        chk("lane.f", f4, 4'b0110);
        chk("lane.g", g4, 4'b0010);
        chk("lane.v", {3'b0, v4}, 4'b0001);

        // Latency: inputs change right after the edge, no comb path
        set1(4'b0000);
        a4 = 4'h0;
        #2;
        chk1("lat_same", 1, 1, 1, 1);
        chk("lat_same.g4", g4, 4'b0010);
        @(posedge clk);
        #1;
        chk1("lat_next", 0, 0, 0, 1);
        chk("lat_next.g4", g4, 4'b0000);

        // en toggling: valid follows en one cycle later
        set1(4'b1100);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk1("tog0", 0, 0, 0, 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk1("tog1", 1, 0, 0, 1);
        en = 1'b0;
        set1(4'b0011);
        @(posedge clk);
        #1;
        chk1("tog2", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
